histogram_peak_finder: RTL
==========================

HISTOGRAM_PEAK_FINDER -- requirements
Module: histogram_peak_finder

Interface
REQ-001 SHALL have parameters: IMAGE_WIDTH, 240, number of x bins; IMAGE_HEIGHT, 180, number of y bins; PEAK_THRESHOLD, 4, minimum bin count for a valid peak; TIMEOUT_CYCLES, 1023, maximum cycles allowed in COLLECT.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle request, driven from filterDone; busy  out  1  high whenever state is not IDLE.
REQ-004 SHALL have ports: readHistogram  out  1  one-cycle read request to the histogram stage; clearHistogram  out  1  one-cycle clear request; ready  in  1  histogram stage idle; histogramClear  in  1  clear-complete pulse.
REQ-005 SHALL have ports: xHistogramOut  in  8  x bin count; xValid  in  1  x bin strobe; yHistogramOut  in  8  y bin count; yValid  in  1  y bin strobe.
REQ-006 SHALL have ports: xPeak  out  8  x bin index of max; yPeak  out  8  y bin index of max; xPeakCount  out  8  max x count; yPeakCount  out  8  max y count; peakValid  out  1  both maxima >= PEAK_THRESHOLD; timeoutError  out  1  collection timed out; peakDone  out  1  one-cycle result strobe.

Function
REQ-007 SHALL implement states IDLE, REQUEST, COLLECT, CLEAR, DONE.
REQ-008 IDLE: on start=1 SHALL go to REQUEST; running maxima, indices, bin counters, and the timeout counter SHALL be zeroed on this transition.
REQ-009 REQUEST: SHALL wait while ready=0; in the first cycle with ready=1, SHALL drive readHistogram=1 for exactly that cycle and go to COLLECT.
REQ-010 COLLECT: each cycle with xValid=1 SHALL treat xHistogramOut as bin index xBinCnt, then increment xBinCnt; the same rule applies independently to y, with xValid and yValid allowed in the same cycle.
REQ-011 Update rule: SHALL replace a running max only when the new count is strictly greater, so ties resolve to the lowest index; the comparison is unsigned 8-bit.
REQ-012 Strobes arriving after xBinCnt reaches IMAGE_WIDTH (or yBinCnt reaches IMAGE_HEIGHT) SHALL be ignored; the bin counters SHALL saturate and not wrap.
REQ-013 COLLECT SHALL exit to CLEAR in the cycle after both bin counters reach their limits; a bin accepted in the final cycle SHALL be included in the result.
REQ-014 The timeout counter SHALL increment each COLLECT cycle; on reaching TIMEOUT_CYCLES, the block SHALL set timeoutError=1 and go to CLEAR with partial results retained.
REQ-015 CLEAR: on entry, SHALL pulse clearHistogram for one cycle; then SHALL wait for histogramClear=1 and go to DONE.
REQ-016 DONE: SHALL update xPeak, yPeak, xPeakCount, yPeakCount, peakValid, and timeoutError, pulse peakDone=1 for one cycle, and return to IDLE; the result outputs SHALL hold until the next DONE or reset.
REQ-017 peakValid SHALL be (xPeakCount >= PEAK_THRESHOLD) AND (yPeakCount >= PEAK_THRESHOLD) AND NOT timeoutError; an all-zero histogram SHALL yield indices 0, counts 0, and peakValid=0.
REQ-018 start asserted outside IDLE SHALL be ignored without being queued; start in the same cycle as peakDone SHALL be ignored.
REQ-019 readHistogram and clearHistogram SHALL never be high in the same cycle, and each SHALL be asserted at most once per run.

Reset
REQ-020 reset=0 SHALL immediately force state IDLE and drive every output to 0, including result registers, busy, and strobes, regardless of the current state.
REQ-021 Deasserting reset mid-run SHALL NOT resume the run; the block SHALL wait in IDLE for a new start.

Verification
REQ-022 Single peak: x bin 37 = 50, y bin 120 = 9, all other bins 1 -> xPeak=37, xPeakCount=50, yPeak=120, yPeakCount=9, peakValid=1, and exactly one peakDone pulse.
REQ-023 Tie and threshold: x bins 10 and 200 = 3, y bin 5 = 3 -> xPeak=10, yPeak=5, peakValid=0 (counts 3 < 4).
REQ-024 Handshake: start while ready=0 for 20 cycles -> readHistogram is a single pulse in the first ready=1 cycle; clearHistogram pulses once; peakDone occurs one cycle after histogramClear.
REQ-025 Interleaved and overflow strobes: x and y strobes in the same cycles, plus 5 extra xValid beats with count 255 -> the extra beats are ignored and results match the reference maxima.
REQ-026 Timeout: only 100 x bins delivered -> timeoutError=1 after 1023 COLLECT cycles, clear handshake completes, peakValid=0.
REQ-027 Reset mid-COLLECT: reset=0 for 1 cycle -> all outputs 0 and busy=0; a following start runs a full, correct sequence.

Source files
------------

// File: rtl/histogram_peak_finder.sv
// histogram_peak_finder: scans streamed x/y histogram bins and
// reports the peak bin index and count of each axis.
module histogram_peak_finder #(
  parameter int IMAGE_WIDTH    = 240,
  parameter int IMAGE_HEIGHT   = 180,
  parameter int PEAK_THRESHOLD = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       readHistogram,
  output logic       clearHistogram,
  input  logic       ready,
  input  logic       histogramClear,
  input  logic [7:0] xHistogramOut,
  input  logic       xValid,
  input  logic [7:0] yHistogramOut,
  input  logic       yValid,
  output logic [7:0] xPeak,
  output logic [7:0] yPeak,
  output logic [7:0] xPeakCount,
  output logic [7:0] yPeakCount,
  output logic       peakValid,
  output logic       timeoutError,
  output logic       peakDone
);

  localparam int XW = $clog2(IMAGE_WIDTH + 1);
  localparam int YW = $clog2(IMAGE_HEIGHT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [XW-1:0] X_LIM  = XW'(IMAGE_WIDTH);
  localparam logic [YW-1:0] Y_LIM  = YW'(IMAGE_HEIGHT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    THR    = 8'(PEAK_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_COLLECT,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XW-1:0] r_xcnt;
  logic [YW-1:0] r_ycnt;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_xmax;
  logic [7:0]    r_ymax;
  logic [7:0]    r_xidx;
  logic [7:0]    r_yidx;
  logic          r_tout;
  logic          r_clr_sent;

  logic [7:0] r_xPeak;
  logic [7:0] r_yPeak;
  logic [7:0] r_xPeakCount;
  logic [7:0] r_yPeakCount;
  logic       r_peakValid;
  logic       r_timeoutError;

  logic w_go;
  logic w_xtake;
  logic w_ytake;
  logic w_bins_done;
  logic w_tout_hit;
  logic w_load;

  assign w_go        = (r_state == S_IDLE) && start;
  assign w_xtake     = xValid && (r_xcnt < X_LIM);
  assign w_ytake     = yValid && (r_ycnt < Y_LIM);
  assign w_bins_done = (r_xcnt == X_LIM) && (r_ycnt == Y_LIM);
  assign w_tout_hit  = (r_tcnt == T_LAST);
  assign w_load      = (r_state == S_CLEAR) && (w_next == S_DONE);

  assign xPeak        = r_xPeak;
  assign yPeak        = r_yPeak;
  assign xPeakCount   = r_xPeakCount;
  assign yPeakCount   = r_yPeakCount;
  assign peakValid    = r_peakValid;
  assign timeoutError = r_timeoutError;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and the one-cycle request/clear/done strobes.
  always_comb begin
    w_next         = r_state;
    busy           = (r_state != S_IDLE);
    readHistogram  = 1'b0;
    clearHistogram = 1'b0;
    peakDone       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_REQUEST;
      end
      S_REQUEST: begin
        if (ready) begin
          readHistogram = 1'b1;
          w_next        = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_bins_done || w_tout_hit) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        clearHistogram = !r_clr_sent;
        if (r_clr_sent && histogramClear) w_next = S_DONE;
      end
      S_DONE: begin
        peakDone = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Running maxima, bin counters and timeout tracking for one run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xcnt     <= '0;
      r_ycnt     <= '0;
      r_tcnt     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_xidx     <= '0;
      r_yidx     <= '0;
      r_tout     <= 1'b0;
      r_clr_sent <= 1'b0;
    end else if (w_go) begin
      r_xcnt     <= '0;
      r_ycnt     <= '0;
      r_tcnt     <= '0;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_xidx     <= '0;
      r_yidx     <= '0;
      r_tout     <= 1'b0;
      r_clr_sent <= 1'b0;
    end else if (r_state == S_COLLECT) begin
      r_tcnt <= r_tcnt + TW'(1);
      if (w_xtake) begin
        if (xHistogramOut > r_xmax) begin
          r_xmax <= xHistogramOut;
          r_xidx <= 8'(r_xcnt);
        end
        r_xcnt <= r_xcnt + XW'(1);
      end
      if (w_ytake) begin
        if (yHistogramOut > r_ymax) begin
          r_ymax <= yHistogramOut;
          r_yidx <= 8'(r_ycnt);
        end
        r_ycnt <= r_ycnt + YW'(1);
      end
      // A run that completes on its last allowed cycle is not a timeout.
      if (!w_bins_done && w_tout_hit) r_tout <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_clr_sent <= 1'b1;
    end
  end

  // Result registers, loaded as the run enters DONE and held after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xPeak        <= '0;
      r_yPeak        <= '0;
      r_xPeakCount   <= '0;
      r_yPeakCount   <= '0;
      r_peakValid    <= 1'b0;
      r_timeoutError <= 1'b0;
    end else if (w_load) begin
      r_xPeak        <= r_xidx;
      r_yPeak        <= r_yidx;
      r_xPeakCount   <= r_xmax;
      r_yPeakCount   <= r_ymax;
      r_peakValid    <= (r_xmax >= THR) && (r_ymax >= THR) && !r_tout;
      r_timeoutError <= r_tout;
    end
  end

endmodule
